q_update_engine: RTL and testbench
==================================

# q_update_engine

Sequential, parametrised Q-learning update engine for the tic-tac-toe agent. It computes Q_new = Q + 2^-a·(reward + 2^-g·max(Q_next) − Q) in signed fixed point using shift-based multiplies. It finds max(Q_next) by scanning the next-state Q-table row through a read port, honouring a legal-action mask and a terminal flag. It sits between the move/reward controller (request side) and the Q-table write-back logic (response side).

## Interface
- Q_W, 16: signed Q-value / reward width.
- NUM_ACT, 9: actions per state (board cells).
- IDX_W, 4: action index width; must satisfy 2^IDX_W ≥ NUM_ACT.
- SH_W, 4: width of alpha/gamma shift amounts.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine idle; accepts a request.
- req_q  in  Q_W  current Q(s,a), signed.
- req_reward  in  Q_W  reward, signed.
- req_alpha_sh  in  SH_W  alpha as right-shift amount.
- req_gamma_sh  in  SH_W  gamma as right-shift amount.
- req_terminal  in  1  next state is terminal; max(Q_next) = 0, no scan.
- req_act_mask  in  NUM_ACT  bit k = 1: action k legal in next state.
- qrd_en  out  1  Q-table read strobe.
- qrd_idx  out  IDX_W  action index read.
- qrd_data  in  Q_W  read data, valid exactly 1 cycle after qrd_en.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_q_new  out  Q_W  updated Q value.
- resp_sat  out  1  result was clipped (present only with Q_UPD_SAT_EN).

## Operation
- States: IDLE, SCAN, DRAIN, CALC, RESP.
- IDLE: req_ready = 1. On req_valid & req_ready, all req_* fields are latched. Next state is CALC if req_terminal, else SCAN.
- SCAN: counter k runs 0..NUM_ACT−1. The engine drives qrd_en = 1 and qrd_idx = k, one read per cycle, all indices, masked or not. After k = NUM_ACT−1, go to DRAIN.
- DRAIN: captures the last read datum, then goes to CALC.
- Max tracker: initialised to the most-negative Q_W value on accept. Each returned datum whose mask bit is set updates max by signed compare. Ties keep the earlier value.
- If the mask is all-zero (non-terminal), max(Q_next) = 0.
- CALC, all in Q_W+2-bit signed:
  - gq = qmax >>> gamma_sh (arithmetic shift).
  - td = reward + gq − q.
  - step = td >>> alpha_sh.
  - sum = q + step.
  - Register the result, then go to RESP.
- Shift amounts ≥ the operand width yield 0 (non-negative operand) or −1 (negative operand).
- RESP: resp_valid = 1 and resp_q_new held stable until resp_ready. On the handshake, return to IDLE. The next request may be accepted in the following cycle.
- qrd_en = 0 outside SCAN. req_ready = 0 outside IDLE.

## Timing
- Reset values: state IDLE, req_ready 1, qrd_en 0, qrd_idx 0, resp_valid 0, resp_q_new 0, resp_sat 0, internal max and latches 0.
- While rst_n is low, requests are ignored.
- Timing is relative to the accept edge at cycle T:
  - Non-terminal: reads at T+1..T+NUM_ACT; DRAIN at T+NUM_ACT+1; CALC at T+NUM_ACT+2; resp_valid at T+NUM_ACT+3 (T+12 for NUM_ACT = 9).
  - Terminal: CALC at T+1; resp_valid at T+2.
- Reset asserted mid-operation aborts the transaction immediately. No response is produced, and outputs take their reset values.

## Configuration
- Q_UPD_SAT_EN defined: sum is clamped to [−2^(Q_W−1), 2^(Q_W−1)−1], and resp_sat = 1 when clamping occurred.
- Q_UPD_SAT_EN undefined: sum is truncated to the low Q_W bits (two's-complement wrap), and the resp_sat port is absent.

## Structure
- Package q_upd_pkg holds:
  - default Q_W, NUM_ACT, SH_W;
  - the state enum;
  - the Q_MIN / Q_MAX constants;
  - the saturate function.
- One sub-module, q_barrel_sra: a parametrised arithmetic right barrel shifter (width, shift-width). It is instantiated twice, for gamma and alpha.

## Test plan
All scenarios use Q_W = 16 and NUM_ACT = 9.
- Basic update:
  - Stimulus: q = 100, reward = 64, alpha_sh = 1, gamma_sh = 1, mask = 0x1FF, table values 0..8 = {10, 200, 5, −3, 0, 7, 1, 2, 9}.
  - Required: qmax = 200, resp_q_new = 132, resp_valid exactly 12 cycles after accept, qrd_idx sequence 0..8.
- Mask with negatives:
  - Stimulus: mask = 0x005, idx0 = −50, idx2 = −10, all others 500, q = 0, reward = 0, alpha_sh = 0, gamma_sh = 0.
  - Required: resp_q_new = −10.
- Terminal:
  - Stimulus: q = 100, reward = −36, alpha_sh = 2, terminal = 1.
  - Required: resp_q_new = 66, qrd_en never asserted, resp_valid at T+2.
- Saturation:
  - Stimulus: q = 0, reward = 32767, table max = 32767, alpha_sh = 0, gamma_sh = 0.
  - Required with Q_UPD_SAT_EN: resp_q_new = 32767, resp_sat = 1.
  - Required without: resp_q_new = −2 (0xFFFE).
- Backpressure:
  - Stimulus: resp_ready held low for 5 cycles; req_valid held high with a second request.
  - Required: resp_q_new stable and req_ready = 0 throughout; second request accepted the cycle after the response handshake.
- Reset mid-scan:
  - Stimulus: rst_n low at T+4.
  - Required: qrd_en = 0, resp_valid = 0, req_ready = 1 after release; a fresh request completes correctly.

Source files
------------

// File: rtl/q_update_engine_pkg.sv
// Shared types, default widths and saturation helper for the Q-learning update engine.
// Saturating build selected by defining Q_UPD_SAT_EN.
package q_upd_pkg;

    localparam int unsigned Q_W_DEF     = 16;
    localparam int unsigned NUM_ACT_DEF = 9;
    localparam int unsigned IDX_W_DEF   = 4;
    localparam int unsigned SH_W_DEF    = 4;

    localparam logic signed [Q_W_DEF-1:0] Q_MIN = {1'b1, {(Q_W_DEF-1){1'b0}}};
    localparam logic signed [Q_W_DEF-1:0] Q_MAX = {1'b0, {(Q_W_DEF-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        CALC,
        RESP
    } state_t;

    typedef struct packed {
        logic               sat;
        logic signed [31:0] val;
    } sat_res_t;

    // Clamp x into the signed range of a w-bit value and flag whether clipping happened.
    function automatic sat_res_t saturate(input logic signed [31:0] x, input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sat_res_t           r;
        hi    = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo    = -hi - 32'sd1;
        r.sat = 1'b0;
        r.val = x;
        if (x > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (x < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/q_update_engine_if.sv
// Request / Q-table read / response bundle between the update engine and its neighbours.
// resp_sat exists only when Q_UPD_SAT_EN is defined.
interface q_update_engine_if
    import q_upd_pkg::*;
#(
    parameter int unsigned Q_W     = Q_W_DEF,
    parameter int unsigned NUM_ACT = NUM_ACT_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned SH_W    = SH_W_DEF
) ();

    logic               req_valid;
    logic               req_ready;
    logic [Q_W-1:0]     req_q;
    logic [Q_W-1:0]     req_reward;
    logic [SH_W-1:0]    req_alpha_sh;
    logic [SH_W-1:0]    req_gamma_sh;
    logic               req_terminal;
    logic [NUM_ACT-1:0] req_act_mask;

    logic               qrd_en;
    logic [IDX_W-1:0]   qrd_idx;
    logic [Q_W-1:0]     qrd_data;

    logic               resp_valid;
    logic               resp_ready;
    logic [Q_W-1:0]     resp_q_new;
`ifdef Q_UPD_SAT_EN
    logic               resp_sat;

    modport master (
        output req_valid, req_q, req_reward, req_alpha_sh, req_gamma_sh, req_terminal, req_act_mask,
        input  req_ready,
        input  qrd_en, qrd_idx,
        output qrd_data,
        input  resp_valid, resp_q_new, resp_sat,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_q, req_reward, req_alpha_sh, req_gamma_sh, req_terminal, req_act_mask,
        output req_ready,
        output qrd_en, qrd_idx,
        input  qrd_data,
        output resp_valid, resp_q_new, resp_sat,
        input  resp_ready
    );
`else
    modport master (
        output req_valid, req_q, req_reward, req_alpha_sh, req_gamma_sh, req_terminal, req_act_mask,
        input  req_ready,
        input  qrd_en, qrd_idx,
        output qrd_data,
        input  resp_valid, resp_q_new,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_q, req_reward, req_alpha_sh, req_gamma_sh, req_terminal, req_act_mask,
        output req_ready,
        output qrd_en, qrd_idx,
        input  qrd_data,
        output resp_valid, resp_q_new,
        input  resp_ready
    );
`endif

endinterface

// File: rtl/q_barrel_sra.sv
// Arithmetic right barrel shifter; shifts at or beyond W fill with the sign bit (0 or -1).
module q_barrel_sra #(
    parameter int unsigned W    = 18,
    parameter int unsigned SH_W = 4
) (
    input  logic signed [W-1:0]    din,
    input  logic        [SH_W-1:0] sh,
    output logic signed [W-1:0]    dout
);

    // >>> on a signed operand sign-fills, so oversized shifts saturate to 0 / -1 naturally.
    assign dout = din >>> sh;

endmodule

// File: rtl/q_update_engine.sv
// Sequential Q-learning update: Q + 2^-a * (r + 2^-g * max(Q_next) - Q), max found by a Q-table row scan.
// Define Q_UPD_SAT_EN to clamp the result and expose resp_sat; otherwise the result wraps.
module q_update_engine
    import q_upd_pkg::*;
#(
    parameter int unsigned Q_W     = Q_W_DEF,
    parameter int unsigned NUM_ACT = NUM_ACT_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned SH_W    = SH_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    q_update_engine_if.slave bus
);

    localparam int unsigned             EW       = Q_W + 2;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_ACT - 1);
    localparam logic signed [Q_W-1:0]   QMIN_W   = {1'b1, {(Q_W-1){1'b0}}};

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    k, k_nxt;
    logic                req_ready_r, req_ready_nxt;
    logic                qrd_en_r, qrd_en_nxt;
    logic                resp_valid_r, resp_valid_nxt;
    logic                accept_c;

    logic signed [Q_W-1:0] q_l, rew_l, qmax, resp_q_new_r;
    logic [SH_W-1:0]       ash_l, gsh_l;
    logic                  term_l;
    logic [NUM_ACT-1:0]    mask_l;
    logic                  rd_pend;
    logic [IDX_W-1:0]      rd_idx;

    logic signed [EW-1:0]  qmax_ext_c, qmax_x_c, q_x_c, rew_x_c, gq_c, td_c, step_c, sum_c;
    logic signed [Q_W-1:0] result_c;

    assign accept_c       = bus.req_valid && req_ready_r;
    assign bus.req_ready  = req_ready_r;
    assign bus.qrd_en     = qrd_en_r;
    assign bus.qrd_idx    = k;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_q_new = resp_q_new_r;

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt = state;
        k_nxt     = '0;
        unique case (state)
            IDLE:  if (accept_c) state_nxt = bus.req_terminal ? CALC : SCAN;
            SCAN: begin
                if (k == LAST_IDX) state_nxt = DRAIN;
                else               k_nxt     = k + 1'b1;
            end
            DRAIN: state_nxt = CALC;
            CALC:  state_nxt = RESP;
            RESP:  if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        req_ready_nxt  = (state_nxt == IDLE);
        qrd_en_nxt     = (state_nxt == SCAN);
        resp_valid_nxt = (state_nxt == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= '0;
            req_ready_r  <= 1'b1;
            qrd_en_r     <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state        <= state_nxt;
            k            <= k_nxt;
            req_ready_r  <= req_ready_nxt;
            qrd_en_r     <= qrd_en_nxt;
            resp_valid_r <= resp_valid_nxt;
        end
    end

    // Request latches, read-return pipeline and running max over legal actions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_l          <= '0;
            rew_l        <= '0;
            ash_l        <= '0;
            gsh_l        <= '0;
            term_l       <= 1'b0;
            mask_l       <= '0;
            qmax         <= '0;
            rd_pend      <= 1'b0;
            rd_idx       <= '0;
            resp_q_new_r <= '0;
        end else begin
            rd_pend <= qrd_en_r;
            rd_idx  <= k;
            if (accept_c) begin
                q_l    <= bus.req_q;
                rew_l  <= bus.req_reward;
                ash_l  <= bus.req_alpha_sh;
                gsh_l  <= bus.req_gamma_sh;
                term_l <= bus.req_terminal;
                mask_l <= bus.req_act_mask;
                qmax   <= QMIN_W;
            end else if (rd_pend && mask_l[rd_idx] && ($signed(bus.qrd_data) > qmax)) begin
                qmax <= $signed(bus.qrd_data);
            end
            if (state == CALC) resp_q_new_r <= result_c;
        end
    end

    // TD datapath in Q_W+2 bits; no legal move or terminal next state means max(Q_next) = 0.
    assign qmax_ext_c = EW'(qmax);
    assign qmax_x_c   = (term_l || (mask_l == '0)) ? '0 : qmax_ext_c;
    assign q_x_c      = EW'(q_l);
    assign rew_x_c    = EW'(rew_l);

    q_barrel_sra #(.W(EW), .SH_W(SH_W)) u_gamma_sra (
        .din  (qmax_x_c),
        .sh   (gsh_l),
        .dout (gq_c)
    );

    assign td_c = rew_x_c + gq_c - q_x_c;

    q_barrel_sra #(.W(EW), .SH_W(SH_W)) u_alpha_sra (
        .din  (td_c),
        .sh   (ash_l),
        .dout (step_c)
    );

    assign sum_c = q_x_c + step_c;

`ifdef Q_UPD_SAT_EN
    sat_res_t sat_c;
    logic     resp_sat_r;

    assign sat_c        = saturate(32'(sum_c), Q_W);
    assign result_c     = Q_W'(sat_c.val);
    assign bus.resp_sat = resp_sat_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              resp_sat_r <= 1'b0;
        else if (state == CALC)  resp_sat_r <= sat_c.sat;
    end
`else
    assign result_c = Q_W'(sum_c);
`endif

endmodule

// File: tb/tb_q_update_engine.sv
// Directed self-checking bench for q_update_engine with a Q-table read model and expected-result scoreboard.
module tb_q_update_engine;
    import q_upd_pkg::*;

    localparam int unsigned QW = 16;
    localparam int unsigned NA = 9;
    localparam int unsigned IW = 4;
    localparam int unsigned SW = 4;

    typedef struct {
        int q_new;
        bit sat;
    } exp_t;

    logic clk;
    logic rst_n;

    q_update_engine_if #(.Q_W(QW), .NUM_ACT(NA), .IDX_W(IW), .SH_W(SW)) bus_i ();

    q_update_engine #(.Q_W(QW), .NUM_ACT(NA), .IDX_W(IW), .SH_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    exp_t               sb[$];
    int                 total = 0;
    int                 bad   = 0;
    logic signed [15:0] tbl[16];
    int                 rd_log[$];
    int                 en_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q-table read port: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus_i.qrd_en === 1'b1) bus_i.qrd_data <= tbl[bus_i.qrd_idx];
        else                       bus_i.qrd_data <= 16'h7ABC;
    end

    always @(negedge clk) begin
        if (bus_i.qrd_en === 1'b1) begin
            rd_log.push_back(int'(bus_i.qrd_idx));
            en_cnt++;
        end
    end

    function automatic int wrap16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    function automatic int model(input int q, input int rew, input int ash, input int gsh,
                                 input bit term, input logic [8:0] mask, output bit sat);
        int qmax, gq, td, step, sum;
        bit any;
        qmax = 0;
        any  = 1'b0;
        if (!term) begin
            for (int i = 0; i < 9; i++) begin
                if (mask[i] && (!any || int'(tbl[i]) > qmax)) begin
                    qmax = int'(tbl[i]);
                    any  = 1'b1;
                end
            end
        end
        gq   = qmax >>> gsh;
        td   = rew + gq - q;
        step = td >>> ash;
        sum  = q + step;
        sat  = 1'b0;
`ifdef Q_UPD_SAT_EN
        if (sum > 32767) begin
            sum = 32767;
            sat = 1'b1;
        end else if (sum < -32768) begin
            sum = -32768;
            sat = 1'b1;
        end
`else
        sum = wrap16(sum);
`endif
        return sum;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int q, input int rew, input int ash, input int gsh,
                             input bit term, input logic [8:0] mask);
        bus_i.req_q        = 16'(q);
        bus_i.req_reward   = 16'(rew);
        bus_i.req_alpha_sh = 4'(ash);
        bus_i.req_gamma_sh = 4'(gsh);
        bus_i.req_terminal = term;
        bus_i.req_act_mask = mask;
        bus_i.req_valid    = 1'b1;
    endtask

    task automatic push_exp(input int q, input int rew, input int ash, input int gsh,
                            input bit term, input logic [8:0] mask);
        exp_t e;
        bit   s;
        e.q_new = model(q, rew, ash, gsh, term, mask, s);
        e.sat   = s;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
    task automatic issue(input string tag, input int q, input int rew, input int ash, input int gsh,
                         input bit term, input logic [8:0] mask);
        int n;
        drive_req(q, rew, ash, gsh, term, mask);
        n = 0;
        while (bus_i.req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, bus_i.req_ready, 1);
        push_exp(q, rew, ash, gsh, term, mask);
        @(posedge clk);
        rd_log.delete();
        en_cnt = 0;
        @(negedge clk);
        bus_i.req_valid = 1'b0;
    endtask

    // Latency counts cycles after the accept edge (first negedge after accept = 1).
    task automatic collect(input string tag, input int exp_lat);
        int   n;
        exp_t e;
        n = 1;
        while (bus_i.resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus_i.resp_valid, 1);
        if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.q_new = 99999;
            e.sat   = 1'b1;
        end
        check({tag, "_q_new"}, $signed(bus_i.resp_q_new), e.q_new);
`ifdef Q_UPD_SAT_EN
        check({tag, "_sat"}, bus_i.resp_sat, int'(e.sat));
`endif
        bus_i.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drop"}, bus_i.resp_valid, 0);
    endtask

    initial begin
        int   seen;
        exp_t e;
        logic [15:0] held;

        for (int i = 0; i < 16; i++) tbl[i] = '0;
        rst_n            = 1'b0;
        bus_i.resp_ready = 1'b1;
        drive_req(5, 5, 0, 0, 1'b0, 9'h1FF);

        // Reset: requests ignored, outputs at reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready",  bus_i.req_ready, 1);
        check("rst_qrd_en",     bus_i.qrd_en, 0);
        check("rst_qrd_idx",    bus_i.qrd_idx, 0);
        check("rst_resp_valid", bus_i.resp_valid, 0);
        check("rst_resp_q_new", $signed(bus_i.resp_q_new), 0);
        check("rst_no_reads",   en_cnt, 0);
`ifdef Q_UPD_SAT_EN
        check("rst_resp_sat",   bus_i.resp_sat, 0);
`endif
        bus_i.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Basic update with full scan
        tbl[0] = 16'sd10; tbl[1] = 16'sd200; tbl[2] = 16'sd5;  tbl[3] = -16'sd3;
        tbl[4] = 16'sd0;  tbl[5] = 16'sd7;   tbl[6] = 16'sd1;  tbl[7] = 16'sd2;  tbl[8] = 16'sd9;
        issue("basic", 100, 64, 1, 1, 1'b0, 9'h1FF);
        collect("basic", 12);
        check("basic_nreads", rd_log.size(), 9);
        for (int i = 0; i < 9; i++) check("basic_idx", (i < rd_log.size()) ? rd_log[i] : -1, i);

        // Sparse mask over negative values
        for (int i = 0; i < 9; i++) tbl[i] = 16'sd500;
        tbl[0] = -16'sd50;
        tbl[2] = -16'sd10;
        issue("maskneg", 0, 0, 0, 0, 1'b0, 9'h005);
        collect("maskneg", 12);

        // Non-terminal with no legal action: max taken as 0
        issue("nomask", 40, -8, 1, 0, 1'b0, 9'h000);
        collect("nomask", 12);

        // Terminal: no scan, short latency
        issue("term", 100, -36, 2, 0, 1'b1, 9'h1FF);
        collect("term", 2);
        check("term_no_reads", en_cnt, 0);

        // Maximum alpha shift on a negative TD gives a step of -1
        issue("bigsh", 10, 0, 15, 0, 1'b1, 9'h000);
        collect("bigsh", 2);

        // Overflow: clamp or wrap depending on build
        for (int i = 0; i < 9; i++) tbl[i] = 16'sd0;
        tbl[4] = 16'sd32767;
        issue("sat", 0, 32767, 0, 0, 1'b0, 9'h1FF);
        collect("sat", 12);

        // Backpressure with a second request waiting
        tbl[0] = 16'sd10; tbl[1] = 16'sd200; tbl[2] = 16'sd5;  tbl[3] = -16'sd3;
        tbl[4] = 16'sd0;  tbl[5] = 16'sd7;   tbl[6] = 16'sd1;  tbl[7] = 16'sd2;  tbl[8] = 16'sd9;
        bus_i.resp_ready = 1'b0;
        issue("bp_a", -300, 120, 2, 1, 1'b0, 9'h0AA);
        seen = 1;
        while (bus_i.resp_valid !== 1'b1 && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        check("bp_a_valid", bus_i.resp_valid, 1);
        if (sb.size() > 0) e = sb.pop_front();
        else e.q_new = 99999;
        check("bp_a_q_new", $signed(bus_i.resp_q_new), e.q_new);
        held = bus_i.resp_q_new;
        drive_req(77, -20, 1, 0, 1'b0, 9'h1F0);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_q",     bus_i.resp_q_new, held);
            check("bp_hold_valid", bus_i.resp_valid, 1);
            check("bp_hold_ready", bus_i.req_ready, 0);
        end
        bus_i.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_after_hs", bus_i.req_ready, 1);
        check("bp_valid_after_hs", bus_i.resp_valid, 0);
        push_exp(77, -20, 1, 0, 1'b0, 9'h1F0);
        @(posedge clk);
        rd_log.delete();
        en_cnt = 0;
        @(negedge clk);
        bus_i.req_valid = 1'b0;
        check("bp_b_taken",   bus_i.req_ready, 0);
        check("bp_b_reading", bus_i.qrd_en, 1);
        collect("bp_b", 12);

        // Reset in the middle of a scan
        issue("rstmid", 55, 11, 1, 1, 1'b0, 9'h1FF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_qrd_en",     bus_i.qrd_en, 0);
        check("rstmid_resp_valid", bus_i.resp_valid, 0);
        check("rstmid_req_ready",  bus_i.req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrel_qrd_en",     bus_i.qrd_en, 0);
        check("rstrel_resp_valid", bus_i.resp_valid, 0);
        check("rstrel_req_ready",  bus_i.req_ready, 1);
        if (sb.size() > 0) void'(sb.pop_front());
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus_i.resp_valid === 1'b1) seen++;
        end
        check("rstmid_no_resp", seen, 0);
        issue("fresh", -200, 50, 3, 2, 1'b0, 9'h0F0);
        collect("fresh", 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
